regfile_ctx_seq: RTL and testbench

//  Context save/restore sequencer for the CPU register file. On a start pulse it

---
 rtl/regfile_ctx_seq.sv | 115 +++++++++++
 tb/tb_regfile_ctx_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_ctx_seq.sv
// regfile_ctx_seq: walks a register mask, saving registers to memory or restoring them over Wishbone.
// Define REGFILE_CTX_TIMEOUT_EN to abort bus transfers that wait TIMEOUT cycles without ack/err.
module regfile_ctx_seq #(
    parameter int WIDTH   = 32,
    parameter int COUNT   = 16,
    parameter int COUNTP  = 4,
    parameter int ADDRW   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              dir_i,
    input  logic [ADDRW-1:0]  base_i,
    input  logic [COUNT-1:0]  mask_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [COUNTP-1:0] rf_read_o,
    input  logic [WIDTH-1:0]  rf_data_i,
    output logic [COUNTP-1:0] rf_waddr_o,
    output logic [WIDTH-1:0]  rf_wdata_o,
    output logic [1:0]        rf_wen_o,
    output logic              bus_cyc_o,
    output logic              bus_stb_o,
    output logic              bus_we_o,
    output logic [ADDRW-1:0]  bus_adr_o,
    output logic [WIDTH-1:0]  bus_dat_o,
    input  logic [WIDTH-1:0]  bus_dat_i,
    input  logic              bus_ack_i,
    input  logic              bus_err_i
);
    typedef enum logic [2:0] {IDLE, NEXT, BUS, WB, DONE} state_t;
    state_t state, state_nx;
    logic [COUNT-1:0] pend;
    logic [ADDRW-1:0] addr;
    logic [WIDTH-1:0] word;
    logic [COUNTP-1:0] cur, idx;
    logic dir, abort;
    logic [1:0] unused_base;
    assign unused_base = base_i[1:0];
`ifdef REGFILE_CTX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] cnt;
    always_ff @(posedge clk_i)
        cnt <= (!rst_i || state != BUS) ? '0 : cnt + 1'b1;
    assign abort = state == BUS && !bus_ack_i && !bus_err_i && cnt == TW'(TIMEOUT - 1);
`else
    localparam int timeout_unused = TIMEOUT;
    assign abort = 1'b0;
`endif
    // Lowest pending register is transferred first, giving ascending order.
    always_comb begin
        idx = '0;
        for (int k = COUNT - 1; k >= 0; k--)
            if (pend[k]) idx = COUNTP'(k);
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_i) state_nx = NEXT;
            NEXT: state_nx = pend == '0 ? DONE : BUS;
            BUS: begin
                if (bus_err_i || abort) state_nx = DONE;
                else if (bus_ack_i) state_nx = dir ? WB : NEXT;
            end
            WB: state_nx = NEXT;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
            pend  <= '0;
            addr  <= '0;
            word  <= '0;
            cur   <= '0;
            dir   <= 1'b0;
            err_o <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start_i) begin
                    pend  <= mask_i;
                    addr  <= {base_i[ADDRW-1:2], 2'b00};
                    dir   <= dir_i;
                    err_o <= 1'b0;
                end
                NEXT: if (pend != '0) begin
                    pend[idx] <= 1'b0;
                    cur       <= idx;
                    if (!dir) word <= rf_data_i;
                end
                BUS: begin
                    if (bus_err_i || abort) err_o <= 1'b1;
                    else if (bus_ack_i && dir) word <= bus_dat_i;
                    else if (bus_ack_i) addr <= addr + ADDRW'(WIDTH / 8);
                end
                WB: addr <= addr + ADDRW'(WIDTH / 8);
                default: ;
            endcase
        end
    end
    assign busy_o     = state != IDLE;
    assign done_o     = state == DONE;
    assign rf_read_o  = state == NEXT ? idx : '0;
    assign rf_waddr_o = state == WB ? cur : '0;
    assign rf_wdata_o = state == WB ? word : '0;
    assign rf_wen_o   = state == WB ? 2'b11 : 2'b00;
    assign bus_cyc_o  = state == BUS;
    assign bus_stb_o  = state == BUS;
    assign bus_we_o   = state == BUS && !dir;
    assign bus_adr_o  = state == BUS ? addr : '0;
    assign bus_dat_o  = word;
endmodule

// File: tb/tb_regfile_ctx_seq.sv
// tb_regfile_ctx_seq: table vectors, corner sequences and random runs against a transfer-list model.
// Covers the REGFILE_CTX_TIMEOUT_EN build as well when the macro is defined.
module tb_regfile_ctx_seq;
    logic clk_i = 0, rst_i = 0, start_i = 0, dir_i = 0;
    logic [31:0] base_i = 0, rf_data_i, rf_wdata_o, bus_adr_o, bus_dat_o, bus_dat_i = 0;
    logic [15:0] mask_i = 0;
    logic busy_o, done_o, err_o, bus_cyc_o, bus_stb_o, bus_we_o;
    logic bus_ack_i = 0, bus_err_i = 0;
    logic [3:0] rf_read_o, rf_waddr_o;
    logic [1:0] rf_wen_o;

    regfile_ctx_seq #(.TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .dir_i(dir_i), .base_i(base_i),
        .mask_i(mask_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .rf_read_o(rf_read_o), .rf_data_i(rf_data_i), .rf_waddr_o(rf_waddr_o),
        .rf_wdata_o(rf_wdata_o), .rf_wen_o(rf_wen_o), .bus_cyc_o(bus_cyc_o),
        .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o),
        .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i),
        .bus_err_i(bus_err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {logic we; logic [31:0] adr; logic [31:0] dat;} txn_t;
    typedef struct {logic dir; logic [31:0] base; logic [15:0] mask; int lat; int err_at; logic exp_err;} vec_t;

    logic [31:0] rf [16];
    logic [31:0] mem [bit [31:0]];
    txn_t log_q[$];
    int n_chk = 0, n_fail = 0;
    int cyc_n = 0, lat = 0, err_at = -1, wcnt = 0, issued = 0;
    int wr_cnt = 0, done_cnt = 0, stb_cycles = 0, c0 = 0;
    bit cur_err;

    assign rf_data_i = rf[rf_read_o];

    // Wishbone slave: ack (or injected err) after lat wait cycles of each strobe.
    always @(negedge clk_i) begin
        if (bus_cyc_o && bus_stb_o) begin
            if (wcnt == 0) begin
                cur_err = issued == err_at;
                issued++;
            end
            if (wcnt >= lat) begin
                bus_ack_i = !cur_err;
                bus_err_i = cur_err;
                bus_dat_i = mem.exists(bus_adr_o) ? mem[bus_adr_o] : 32'hDEAD_BEEF;
            end
            wcnt++;
        end else begin
            bus_ack_i = 0;
            bus_err_i = 0;
            wcnt = 0;
        end
    end

    always @(posedge clk_i) begin
        cyc_n++;
        if (bus_cyc_o && bus_stb_o) begin
            stb_cycles++;
            if (bus_ack_i && !bus_err_i) begin
                log_q.push_back('{bus_we_o, bus_adr_o, bus_we_o ? bus_dat_o : bus_dat_i});
                if (bus_we_o) mem[bus_adr_o] = bus_dat_o;
            end
        end
        if (rf_wen_o == 2'b11) begin
            rf[rf_waddr_o] = rf_wdata_o;
            wr_cnt++;
        end
        if (done_o) done_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_stats(input int l, input int e);
        log_q.delete();
        wr_cnt = 0; done_cnt = 0; stb_cycles = 0; issued = 0;
        lat = l; err_at = e;
    endtask

    task automatic kick(input logic d, input logic [31:0] b, input logic [15:0] m);
        @(negedge clk_i);
        dir_i = d; base_i = b; mask_i = m; start_i = 1; c0 = cyc_n;
        @(negedge clk_i);
        start_i = 0;
    endtask

    task automatic wait_done(input int limit, output bit got, output int c1);
        got = 0; c1 = 0;
        for (int t = 0; t < limit && !got; t++) begin
            @(negedge clk_i);
            if (done_o) begin got = 1; c1 = cyc_n; end
        end
    endtask

    task automatic wait_stb(input string name);
        bit got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk_i);
            got = bus_stb_o;
        end
        check(name, 64'(got), 1);
    endtask

    // Reference: the n-th set mask bit maps to word-aligned base + 4n.
    task automatic run_check(input vec_t v);
        logic [31:0] exp_rf [16];
        txn_t exp_q[$];
        int n = 0, pc, comp, iss;
        bit got;
        int c1;
        logic [31:0] a;
        pc = $countones(v.mask);
        comp = (v.err_at >= 0 && v.err_at < pc) ? v.err_at : pc;
        iss = (v.err_at >= 0 && v.err_at < pc) ? v.err_at + 1 : pc;
        exp_rf = rf;
        for (int k = 0; k < 16; k++) begin
            if (v.mask[k]) begin
                a = (v.base & 32'hFFFF_FFFC) + 32'(4 * n);
                if (v.dir && !mem.exists(a)) mem[a] = $urandom;
                if (n < comp) begin
                    exp_q.push_back('{!v.dir, a, v.dir ? mem[a] : rf[k]});
                    if (v.dir) exp_rf[k] = mem[a];
                end
                n++;
            end
        end
        clear_stats(v.lat, v.err_at);
        kick(v.dir, v.base, v.mask);
        wait_done(2000, got, c1);
        check("done_seen", 64'(got), 1);
        if (v.err_at < 0)
            check("latency", 64'(c1 - c0), 64'(2 + pc * (2 + v.lat + int'(v.dir))));
        repeat (2) @(negedge clk_i);
        check("done_pulses", 64'(done_cnt), 1);
        check("err", 64'(err_o), 64'(v.exp_err));
        check("busy_after", 64'(busy_o), 0);
        check("issued", 64'(issued), 64'(iss));
        check("txn_count", 64'(log_q.size()), 64'(comp));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check($sformatf("txn%0d_we", i), 64'(log_q[i].we), 64'(exp_q[i].we));
            check($sformatf("txn%0d_adr", i), 64'(log_q[i].adr), 64'(exp_q[i].adr));
            check($sformatf("txn%0d_dat", i), 64'(log_q[i].dat), 64'(exp_q[i].dat));
        end
        check("rf_writes", 64'(wr_cnt), v.dir ? 64'(comp) : 0);
        for (int k = 0; k < 16; k++)
            check($sformatf("rf%0d", k), 64'(rf[k]), 64'(exp_rf[k]));
    endtask

    vec_t vecs[6];
    initial begin
        bit got;
        int c1, pc;
        vec_t v;
        vecs[0] = '{0, 32'h1003, 16'h8005, 0, -1, 0};
        vecs[1] = '{1, 32'h2000, 16'h0006, 2, -1, 0};
        vecs[2] = '{0, 32'h2800, 16'h0000, 0, -1, 0};
        vecs[3] = '{0, 32'h3000, 16'h0111, 1, 1, 1};
        vecs[4] = '{1, 32'h4000, 16'h8001, 0, -1, 0};
        vecs[5] = '{0, 32'hFFFF_FFF8, 16'h000F, 1, -1, 0};
        for (int k = 0; k < 16; k++) rf[k] = $urandom;

        repeat (3) @(negedge clk_i);
        check("reset_ctl", 64'({busy_o, done_o, err_o, bus_cyc_o, bus_stb_o, bus_we_o, rf_wen_o}), 0);
        check("reset_adr", 64'(bus_adr_o), 0);
        check("reset_rf_ports", 64'({rf_read_o, rf_waddr_o, rf_wdata_o}), 0);
        rst_i = 1;

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 16; k++) rf[k] = $urandom;
            if (i == 0) begin rf[0] = 32'h11; rf[2] = 32'h22; rf[15] = 32'hFF; end
            if (i == 1) begin mem[32'h2000] = 32'hA; mem[32'h2004] = 32'hB; end
            run_check(vecs[i]);
            if (i == 0) begin
                check("mem1000", 64'(mem[32'h1000]), 64'h11);
                check("mem1004", 64'(mem[32'h1004]), 64'h22);
                check("mem1008", 64'(mem[32'h1008]), 64'hFF);
            end
            if (i == 1) begin
                check("r1_restored", 64'(rf[1]), 64'hA);
                check("r2_restored", 64'(rf[2]), 64'hB);
            end
            if (i == 2) check("empty_no_bus", 64'(stb_cycles), 0);
        end

        // Start while busy must be ignored.
        clear_stats(2, -1);
        kick(0, 32'h5000, 16'h00F0);
        repeat (3) @(negedge clk_i);
        start_i = 1; dir_i = 1; mask_i = 16'hFFFF;
        @(negedge clk_i);
        start_i = 0;
        wait_done(500, got, c1);
        check("busy_start_done", 64'(got), 1);
        check("busy_start_txns", 64'(log_q.size()), 4);
        check("busy_start_writes", 64'(wr_cnt), 0);
        repeat (2) @(negedge clk_i);
        check("busy_start_idle", 64'(busy_o), 0);

        // Never-acked transfer.
        clear_stats(1000000, -1);
        kick(0, 32'h6000, 16'h0001);
        wait_stb("hang_stb_seen");
`ifdef REGFILE_CTX_TIMEOUT_EN
        wait_done(50, got, c1);
        check("timeout_done", 64'(got), 1);
        check("timeout_stb_cycles", 64'(stb_cycles), 8);
        check("timeout_err", 64'(err_o), 1);
        @(negedge clk_i);
        check("timeout_stb_low", 64'({bus_cyc_o, bus_stb_o}), 0);
`else
        repeat (300) @(negedge clk_i);
        check("hang_stb_high", 64'(bus_stb_o), 1);
        check("hang_busy", 64'(busy_o), 1);
        rst_i = 0;
        @(negedge clk_i);
        rst_i = 1;
`endif
        check("hang_no_done", 64'(done_cnt), 64'(stb_cycles == 8 ? 1 : 0));

        // Reset while a restore is waiting in BUS.
        clear_stats(5, -1);
        kick(1, 32'h7000, 16'h0003);
        wait_stb("rst_stb_seen");
        @(negedge clk_i);
        rst_i = 0;
        @(negedge clk_i);
        check("rst_bus_low", 64'({bus_cyc_o, bus_stb_o}), 0);
        check("rst_busy", 64'(busy_o), 0);
        check("rst_done_err", 64'({done_o, err_o}), 0);
        check("rst_no_rf_write", 64'(wr_cnt), 0);
        rst_i = 1;

        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < 16; k++) rf[k] = $urandom;
            v.dir = 1'($urandom);
            v.base = $urandom;
            v.mask = 16'($urandom & $urandom_range(0, 1) ? $urandom : 32'h0000_FFFF);
            v.lat = $urandom_range(0, 3);
            pc = $countones(v.mask);
            v.err_at = ($urandom_range(0, 3) == 0 && pc > 0) ? $urandom_range(0, pc - 1) : -1;
            v.exp_err = v.err_at >= 0;
            run_check(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
